// File: rtl/alu_driver.sv
// Clocked sequencing front end for the combinational alu: registers a command onto the ALU
// ports, waits SETTLE_CYCLES, captures result/flags. Optional macro: ALU_DRIVER_CHAIN_EN.
//
// state  | meaning
// IDLE   | ready for a command; alu_* hold the last command
// WAIT   | operands held on the ALU while the settle counter runs down
// RESP   | captured result presented until rsp_ready
module alu_driver #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [3:0]       cmd_op,
    input  logic             cmd_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [15:0]      op_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0]       state;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] next_a;
    logic             capture;

    assign cmd_ready = (state == S_IDLE) && !rst;
    assign capture   = (state == S_WAIT) && (settle_cnt == 4'd0);

`ifdef ALU_DRIVER_CHAIN_EN
    logic [WIDTH-1:0] last_result;

    assign next_a = cmd_chain ? last_result : cmd_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_result <= '0;
        end else if (capture) begin
            last_result <= alu_out;
        end
    end
`else
    logic unused_chain;

    assign unused_chain = cmd_chain;
    assign next_a       = cmd_a;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            settle_cnt <= 4'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= 3'd0;
            op_count   <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        alu_a      <= next_a;
                        alu_b      <= cmd_b;
                        alu_op     <= cmd_op;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (capture) begin
                        rsp_result <= alu_out;
                        rsp_flags  <= {alu_negative, alu_zero, alu_overflow};
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    // cmd_ready stays low on the retire cycle; next acceptance is one cycle later
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_driver.sv
// Self-checking bench for alu_driver: two instances (settle 1 and 3) each driving an adder ALU stub.
module tb_alu_driver;

    localparam int W = 32;
`ifdef ALU_DRIVER_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         cmd_valid;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [3:0]   cmd_op;
    logic         cmd_chain;
    logic         rsp_ready;

    logic         cr1, rv1, n1, z1, v1;
    logic [W-1:0] a1, b1, ao1, rr1;
    logic [3:0]   op1;
    logic [2:0]   rf1;
    logic [15:0]  oc1;

    logic         cr3, rv3, n3, z3, v3;
    logic [W-1:0] a3, b3, ao3, rr3;
    logic [3:0]   op3;
    logic [2:0]   rf3;
    logic [15:0]  oc3;

    // adder stub standing in for the ALU
    assign ao1 = a1 + b1;
    assign n1  = ao1[W-1];
    assign z1  = (ao1 == '0);
    assign v1  = (a1[W-1] == b1[W-1]) && (ao1[W-1] != a1[W-1]);
    assign ao3 = a3 + b3;
    assign n3  = ao3[W-1];
    assign z3  = (ao3 == '0);
    assign v3  = (a3[W-1] == b3[W-1]) && (ao3[W-1] != a3[W-1]);

    alu_driver #(.WIDTH(W), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cr1),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
        .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_out(ao1),
        .alu_negative(n1), .alu_zero(z1), .alu_overflow(v1),
        .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_result(rr1),
        .rsp_flags(rf1), .op_count(oc1)
    );

    alu_driver #(.WIDTH(W), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cr3),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
        .alu_a(a3), .alu_b(b3), .alu_op(op3), .alu_out(ao3),
        .alu_negative(n3), .alu_zero(z3), .alu_overflow(v3),
        .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_result(rr3),
        .rsp_flags(rf3), .op_count(oc3)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0]  m_count;
    logic [W-1:0] m_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference: {result, negative, zero, overflow} from two's-complement arithmetic
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb, ss;
        logic [W-1:0] res;
        logic         n, z, v;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ss  = sa + sb;
        res = W'(ss);
        n   = ($signed(res) < 0);
        z   = (res == 0);
        v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        return {res, n, z, v};
    endfunction

    // one full command on the settle-1 instance, starting and ending at a negedge in IDLE
    task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                           input logic chain, input int hold);
        logic [W-1:0] ea;
        logic [W+2:0] m;
        int           k;
        ea        = (CHAIN_EN && chain) ? m_last : a;
        m         = model(ea, b);
        rsp_ready = (hold == 0);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_chain = chain;
        k = 0;
        while (!cr1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("accept_ready", cr1, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_chain = 1'b0;
        chk("alu_a", a1, ea);
        chk("alu_b", b1, b);
        chk("alu_op", op1, op);
        chk("busy_ready", cr1, 0);
        k = 0;
        while (!rv1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("settle_latency", k, 1);
        chk("result", rr1, m[W+2:3]);
        chk("flags", rf1, m[2:0]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rv1, 1);
            chk("hold_result", rr1, m[W+2:3]);
            chk("hold_ready", cr1, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        m_count = m_count + 16'd1;
        m_last  = m[W+2:3];
        chk("retire_valid", rv1, 0);
        chk("op_count", oc1, m_count);
        chk("idle_ready", cr1, 1);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = 4'd0;
        cmd_chain = 1'b0;
        rsp_ready = 1'b1;
        m_count   = 16'd0;
        m_last    = '0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", cr1, 0);
        chk("rst_alu_a", a1, 0);
        chk("rst_alu_b", b1, 0);
        chk("rst_alu_op", op1, 0);
        chk("rst_valid", rv1, 0);
        chk("rst_result", rr1, 0);
        chk("rst_flags", rf1, 0);
        chk("rst_count", oc1, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cr1, 1);

        // basic add, settle 1
        cmd_valid = 1'b1;
        cmd_a     = 32'h5555AAAA;
        cmd_b     = 32'h44442222;
        cmd_op    = 4'h4;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("basic_op", op1, 4'h4);
        chk("basic_a", a1, 32'h5555AAAA);
        chk("basic_valid_e0", rv1, 0);
        chk("basic_ready_e0", cr1, 0);
        @(negedge clk);
        chk("basic_valid_e1", rv1, 1);
        chk("basic_result", rr1, 32'h9999CCCC);
        chk("basic_flags", rf1, 3'b101);
        chk("basic_count_e1", oc1, 0);
        @(negedge clk);
        chk("basic_valid_e2", rv1, 0);
        chk("basic_count_e2", oc1, 1);
        chk("basic_ready_e2", cr1, 1);

        // backpressure with a second command waiting
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_a     = 32'd1;
        cmd_b     = 32'd2;
        cmd_op    = 4'h1;
        @(negedge clk);
        cmd_a = 32'h100;
        cmd_b = 32'h200;
        @(negedge clk);
        chk("bp_valid", rv1, 1);
        chk("bp_result", rr1, 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", rv1, 1);
            chk("bp_hold_result", rr1, 32'd3);
            chk("bp_hold_flags", rf1, 3'b000);
            chk("bp_hold_ready", cr1, 0);
            chk("bp_hold_alu_a", a1, 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_retire_valid", rv1, 0);
        chk("bp_retire_ready", cr1, 1);
        chk("bp_not_yet_taken", a1, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_second_a", a1, 32'h100);
        chk("bp_second_ready", cr1, 0);
        @(negedge clk);
        chk("bp_second_result", rr1, 32'h300);
        @(negedge clk);
        chk("bp_count", oc1, 3);

        // zero result with settle 3
        rst = 1'b1;
        @(negedge clk);
        chk("rst_hi_ready3", cr3, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready3", cr3, 1);
        cmd_valid = 1'b1;
        cmd_a     = 32'hFFFFFFFF;
        cmd_b     = 32'h1;
        cmd_op    = 4'h4;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("s3_valid_e0", rv3, 0);
        @(negedge clk);
        chk("s3_valid_e1", rv3, 0);
        @(negedge clk);
        chk("s3_valid_e2", rv3, 0);
        @(negedge clk);
        chk("s3_valid_e3", rv3, 1);
        chk("s3_result", rr3, 0);
        chk("s3_flags", rf3, 3'b010);
        @(negedge clk);
        chk("s3_retire", rv3, 0);
        chk("s3_count", oc3, 1);

        // reset mid-WAIT
        cmd_valid = 1'b1;
        cmd_a     = 32'd7;
        cmd_b     = 32'd8;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_alu_a", a3, 7);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_valid", rv3, 0);
        chk("mid_alu_a_rst", a3, 0);
        chk("mid_flags", rf3, 0);
        chk("mid_count", oc3, 0);
        chk("mid_ready_rst", cr3, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ready_after", cr3, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", rv3, 0);
            chk("mid_no_count", oc3, 0);
        end

        // randomized commands against the model (settle-1 instance, fresh from reset)
        m_count = 16'd0;
        m_last  = '0;
        for (int i = 0; i < 16; i++) begin
            run_cmd($urandom, $urandom, 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        run_cmd(32'h7FFFFFFF, 32'h1, 4'h4, 1'b0, 0);
        run_cmd(32'h80000000, 32'h80000000, 4'h4, 1'b0, 1);

        // chained operand
        run_cmd(32'd5, 32'd7, 4'h4, 1'b0, 0);
        run_cmd(32'hDEAD, 32'd3, 4'h4, 1'b1, 0);
        chk("chain_alu_a", a1, CHAIN_EN ? 32'd12 : 32'hDEAD);
        chk("chain_result", rr1, CHAIN_EN ? 32'd15 : 32'hDEAD + 32'd3);

        // op_count wrap from a preloaded value
        force u_dut1.op_count = 16'hFFFE;
        #1;
        release u_dut1.op_count;
        m_count = 16'hFFFE;
        run_cmd(32'd1, 32'd1, 4'h4, 1'b0, 0);
        run_cmd(32'd2, 32'd2, 4'h4, 1'b0, 0);
        chk("count_wrap", oc1, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
